clock_div_prog: RTL



---
 rtl/clock_div_prog_if.sv | 25 ++
 rtl/clock_div_prog.sv | 122 ++++++++++++
 2 files changed

// File: rtl/clock_div_prog_if.sv
// rtl/clock_div_prog_if.sv - configuration, run-control and output bundle of the programmable tick generator
interface clock_div_prog_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 24,
  parameter int CH_W   = 2
);
  logic              cfg_we_i;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [DIV_W-1:0]  cfg_half_i;
  logic [NUM_CH-1:0] en_i;
  logic              sync_i;
  logic [NUM_CH-1:0] clk_o;
  logic [NUM_CH-1:0] tick_o;
  logic              cfg_err_o;

  modport master (
    output cfg_we_i, cfg_ch_i, cfg_half_i, en_i, sync_i,
    input  clk_o, tick_o, cfg_err_o
  );

  modport slave (
    input  cfg_we_i, cfg_ch_i, cfg_half_i, en_i, sync_i,
    output clk_o, tick_o, cfg_err_o
  );
endinterface

// File: rtl/clock_div_prog.sv
// rtl/clock_div_prog.sv - multi-channel 50%-duty clock/tick generator with glitch-free runtime half-period reload
module clock_div_prog #(
  parameter int FREQ_SYSCLK = 12_000_000,
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 24,
  parameter int DEF_HALF    = FREQ_SYSCLK / 16,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk_sys_i,
  input  logic            rst_n_i,
  clock_div_prog_if.slave bus
);
  localparam logic [CH_W:0]    NUM_CH_W  = (CH_W + 1)'(NUM_CH);
  localparam logic [DIV_W-1:0] DEF_HALF_W = DIV_W'(DEF_HALF);

  logic [DIV_W-1:0]  cnt_q  [NUM_CH];
  logic [DIV_W-1:0]  cnt_d  [NUM_CH];
  logic [DIV_W-1:0]  half_q [NUM_CH];
  logic [DIV_W-1:0]  half_d [NUM_CH];
  logic [DIV_W-1:0]  pend_q [NUM_CH];
  logic [DIV_W-1:0]  pend_d [NUM_CH];
  logic [NUM_CH-1:0] pend_v_q, pend_v_d;
  logic [NUM_CH-1:0] clk_q, clk_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic              cfg_err_q, cfg_err_d;

  logic              ch_ok;
  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] run;
  logic [NUM_CH-1:0] term;

  assign ch_ok     = ({1'b0, bus.cfg_ch_i} < NUM_CH_W);
  assign cfg_err_d = bus.cfg_we_i && !ch_ok;

  always_comb begin
    wr_hit = '0;
    run    = '0;
    term   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      wr_hit[n] = bus.cfg_we_i && ch_ok && (bus.cfg_ch_i == CH_W'(n));
      run[n]    = bus.en_i[n] && (half_q[n] != '0);
      // >= rather than == so a counter left beyond a shrunken half still wraps
      term[n]   = run[n] && (cnt_q[n] >= (half_q[n] - DIV_W'(1)));
    end
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      cnt_d[n]    = cnt_q[n];
      half_d[n]   = half_q[n];
      pend_d[n]   = pend_q[n];
      pend_v_d[n] = pend_v_q[n];
      clk_d[n]    = clk_q[n];
      tick_d[n]   = 1'b0;
      if (bus.sync_i) begin
        cnt_d[n]    = '0;
        clk_d[n]    = 1'b0;
        pend_v_d[n] = 1'b0;
        if (wr_hit[n]) begin
          half_d[n] = bus.cfg_half_i;
        end else if (pend_v_q[n]) begin
          half_d[n] = pend_q[n];
        end
      end else if (run[n]) begin
        if (term[n]) begin
          cnt_d[n]  = '0;
          clk_d[n]  = ~clk_q[n];
          tick_d[n] = ~clk_q[n];
          if (pend_v_q[n]) begin
            half_d[n]   = pend_q[n];
            pend_v_d[n] = 1'b0;
          end
        end else begin
          cnt_d[n] = cnt_q[n] + DIV_W'(1);
        end
        // a write landing on the boundary is queued for the next one
        if (wr_hit[n]) begin
          pend_d[n]   = bus.cfg_half_i;
          pend_v_d[n] = 1'b1;
        end
      end else begin
        if (half_q[n] == '0) begin
          cnt_d[n] = '0;
          clk_d[n] = 1'b0;
        end
        if (wr_hit[n]) begin
          half_d[n]   = bus.cfg_half_i;
          cnt_d[n]    = '0;
          pend_v_d[n] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n]  <= '0;
        half_q[n] <= DEF_HALF_W;
        pend_q[n] <= '0;
      end
      pend_v_q  <= '0;
      clk_q     <= '0;
      tick_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        cnt_q[n]  <= cnt_d[n];
        half_q[n] <= half_d[n];
        pend_q[n] <= pend_d[n];
      end
      pend_v_q  <= pend_v_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign bus.clk_o     = clk_q;
  assign bus.tick_o    = tick_q;
  assign bus.cfg_err_o = cfg_err_q;
endmodule
